// File: rtl/ptos_pkg.sv
// Shared types and sizing helpers for the ptos_serializer block.
package ptos_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  function automatic int beats_f(input int data_width, input int lanes);
    return (lanes > 0) ? (data_width / lanes) : 1;
  endfunction

  function automatic int cnt_width_f(input int data_width, input int lanes);
    return $clog2(beats_f(data_width, lanes) + 1);
  endfunction

endpackage

// File: rtl/ptos_hold_reg.sv
// One-entry holding register: captures a word while the shifter is busy and
// releases it when the shifter finishes the current word.
module ptos_hold_reg
  import ptos_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  unload,
  input  logic [DATA_WIDTH-1:0] din,
  output logic                  full,
  output logic [DATA_WIDTH-1:0] dout
);

  logic                  full_r;
  logic [DATA_WIDTH-1:0] data_r;

  // Full flag and stored word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_r <= 1'b0;
      data_r <= {DATA_WIDTH{1'b0}};
    end else if (load) begin
      full_r <= 1'b1;
      data_r <= din;
    end else if (unload) begin
      full_r <= 1'b0;
    end
  end

  assign full = full_r;
  assign dout = data_r;

endmodule

// File: rtl/ptos_serializer.sv
// Parallel-to-serial converter emitting DATA_WIDTH/LANES beats per word.
// Optional trailing even-parity beat when PTOS_PARITY_EN is defined.
module ptos_serializer
  import ptos_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 1,
  parameter int MSB_FIRST  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  din_valid,
  output logic                  din_ready,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [LANES-1:0]      dout,
  output logic                  dout_valid,
  output logic                  dout_first,
  output logic                  dout_last,
  output logic                  busy
);

  localparam int BEATS = beats_f(DATA_WIDTH, LANES);
  localparam int CW    = cnt_width_f(DATA_WIDTH, LANES);
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

  generate
    if (DATA_WIDTH < 1 || LANES < 1 || (DATA_WIDTH % LANES) != 0) begin : g_param_check
      $error("ptos_serializer: LANES must be >= 1 and divide DATA_WIDTH");
    end
  endgenerate

  state_t                state_r, state_s;
  logic [CW-1:0]         cnt_r, cnt_s;
  logic [DATA_WIDTH-1:0] shift_r, shift_s;
  logic                  load_s, unload_s, accept_s, word_end_s, full_next_s;
  logic                  hold_full_s;
  logic [DATA_WIDTH-1:0] hold_data_s;
  logic [LANES-1:0]      dout_s, dout_r;
  logic                  first_s, last_s, valid_s, busy_s;
  logic                  first_r, last_r, valid_r, busy_r, din_ready_r;
`ifdef PTOS_PARITY_EN
  logic                  parity_r, parity_s;

  function automatic logic parity_f(input logic [DATA_WIDTH-1:0] w);
    return ^w;
  endfunction
`endif

  function automatic logic [LANES-1:0] beat_of(input logic [DATA_WIDTH-1:0] w);
    if (MSB_FIRST != 0) begin
      return w[DATA_WIDTH-1 -: LANES];
    end else begin
      return w[LANES-1:0];
    end
  endfunction

  function automatic logic [DATA_WIDTH-1:0] shift_word(input logic [DATA_WIDTH-1:0] w);
    if (MSB_FIRST != 0) begin
      return w << LANES;
    end else begin
      return w >> LANES;
    end
  endfunction

  ptos_hold_reg #(.DATA_WIDTH(DATA_WIDTH)) u_hold (
    .clk    (clk),
    .rst    (rst),
    .load   (load_s),
    .unload (unload_s),
    .din    (din),
    .full   (hold_full_s),
    .dout   (hold_data_s)
  );

  assign accept_s = din_valid && din_ready_r;
`ifdef PTOS_PARITY_EN
  assign word_end_s = (state_r == PARITY);
`else
  assign word_end_s = (state_r == SHIFT) && (cnt_r == LAST_BEAT);
`endif
  assign full_next_s = load_s | (hold_full_s & ~unload_s);

  // Next state, shifter and holding-register strobes
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    shift_s  = shift_r;
    load_s   = 1'b0;
    unload_s = 1'b0;
`ifdef PTOS_PARITY_EN
    parity_s = parity_r;
`endif
    if (word_end_s) begin
      // A held word has priority; it was accepted before any word offered now
      if (hold_full_s) begin
        unload_s = 1'b1;
        state_s  = SHIFT;
        cnt_s    = {CW{1'b0}};
        shift_s  = hold_data_s;
`ifdef PTOS_PARITY_EN
        parity_s = parity_f(hold_data_s);
`endif
      end else if (accept_s) begin
        state_s  = SHIFT;
        cnt_s    = {CW{1'b0}};
        shift_s  = din;
`ifdef PTOS_PARITY_EN
        parity_s = parity_f(din);
`endif
      end else begin
        state_s  = IDLE;
        cnt_s    = {CW{1'b0}};
        shift_s  = {DATA_WIDTH{1'b0}};
      end
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            state_s  = SHIFT;
            cnt_s    = {CW{1'b0}};
            shift_s  = din;
`ifdef PTOS_PARITY_EN
            parity_s = parity_f(din);
`endif
          end else begin
            state_s  = IDLE;
          end
        end
        SHIFT: begin
          load_s = accept_s;
`ifdef PTOS_PARITY_EN
          if (cnt_r != LAST_BEAT) begin
            cnt_s   = cnt_r + CW'(1);
            shift_s = shift_word(shift_r);
          end else begin
            state_s = PARITY;
            shift_s = {DATA_WIDTH{1'b0}};
          end
`else
          cnt_s   = cnt_r + CW'(1);
          shift_s = shift_word(shift_r);
`endif
        end
        default: begin
          state_s = IDLE;
          cnt_s   = {CW{1'b0}};
          shift_s = {DATA_WIDTH{1'b0}};
        end
      endcase
    end
  end

  // Output values for the beat that will be on dout after this edge
  always_comb begin
    dout_s  = {LANES{1'b0}};
    first_s = 1'b0;
    last_s  = 1'b0;
    case (state_s)
      SHIFT: begin
        dout_s  = beat_of(shift_s);
        first_s = (cnt_s == {CW{1'b0}});
`ifdef PTOS_PARITY_EN
        last_s  = 1'b0;
`else
        last_s  = (cnt_s == LAST_BEAT);
`endif
      end
`ifdef PTOS_PARITY_EN
      PARITY: begin
        dout_s[0] = parity_s;
        last_s    = 1'b1;
      end
`endif
      default: begin
        dout_s  = {LANES{1'b0}};
      end
    endcase
  end

  assign valid_s = (state_s != IDLE);
  assign busy_s  = valid_s | full_next_s;

  // State, datapath and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      cnt_r       <= {CW{1'b0}};
      shift_r     <= {DATA_WIDTH{1'b0}};
      dout_r      <= {LANES{1'b0}};
      valid_r     <= 1'b0;
      first_r     <= 1'b0;
      last_r      <= 1'b0;
      busy_r      <= 1'b0;
      din_ready_r <= 1'b1;
`ifdef PTOS_PARITY_EN
      parity_r    <= 1'b0;
`endif
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      shift_r     <= shift_s;
      dout_r      <= dout_s;
      valid_r     <= valid_s;
      first_r     <= first_s;
      last_r      <= last_s;
      busy_r      <= busy_s;
      din_ready_r <= ~full_next_s;
`ifdef PTOS_PARITY_EN
      parity_r    <= parity_s;
`endif
    end
  end

  assign din_ready  = din_ready_r;
  assign dout       = dout_r;
  assign dout_valid = valid_r;
  assign dout_first = first_r;
  assign dout_last  = last_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_ptos_serializer.sv
// Self-checking bench: two configurations (8x1 LSB-first, 8x2 MSB-first) share
// one stimulus stream; each is compared every cycle against a beat-queue model.
module tb_ptos_serializer;

`ifdef PTOS_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int PW0 = 8 + PAR;
  localparam int PW1 = 4 + PAR;

  typedef struct packed {
    logic [7:0] d;
    logic       f;
    logic       l;
  } beat_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       din_valid = 1'b0;
  logic [7:0] din = 8'h00;
  logic       din_ready0, dout_valid0, dout_first0, dout_last0, busy0;
  logic [0:0] dout0;
  logic       din_ready1, dout_valid1, dout_first1, dout_last1, busy1;
  logic [1:0] dout1;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;
  beat_t q0[$];
  beat_t q1[$];

  always #5 clk = ~clk;

  ptos_serializer #(.DATA_WIDTH(8), .LANES(1), .MSB_FIRST(0)) dut0 (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din_ready(din_ready0), .din(din),
    .dout(dout0), .dout_valid(dout_valid0), .dout_first(dout_first0),
    .dout_last(dout_last0), .busy(busy0));

  ptos_serializer #(.DATA_WIDTH(8), .LANES(2), .MSB_FIRST(1)) dut1 (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din_ready(din_ready1), .din(din),
    .dout(dout1), .dout_valid(dout_valid1), .dout_first(dout_first1),
    .dout_last(dout_last1), .busy(busy1));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Beat k of word w; k == 8/lanes is the parity beat
  function automatic beat_t mk_beat(input logic [7:0] w, input int lanes, input int msb, input int k);
    beat_t b;
    int nb;
    logic [7:0] mask;
    nb   = 8 / lanes;
    mask = 8'((1 << lanes) - 1);
    b.f  = (k == 0);
    if (k < nb) begin
      if (msb != 0) b.d = 8'(w >> (8 - lanes * (k + 1))) & mask;
      else          b.d = 8'(w >> (lanes * k)) & mask;
      b.l = (k == nb - 1) && (PAR == 0);
    end else begin
      b.d = {7'd0, ^w};
      b.l = 1'b1;
    end
    return b;
  endfunction

  // Model: each edge retires the displayed beat and appends the beats of an accepted word
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q0.delete();
      q1.delete();
    end else begin
      if (din_valid && (q0.size() <= PW0)) begin
        if (q0.size() != 0) void'(q0.pop_front());
        for (int k = 0; k < PW0; k++) q0.push_back(mk_beat(din, 1, 0, k));
      end else if (q0.size() != 0) begin
        void'(q0.pop_front());
      end
      if (din_valid && (q1.size() <= PW1)) begin
        if (q1.size() != 0) void'(q1.pop_front());
        for (int k = 0; k < PW1; k++) q1.push_back(mk_beat(din, 2, 1, k));
      end else if (q1.size() != 0) begin
        void'(q1.pop_front());
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("d0 valid", 32'(dout_valid0), 32'(q0.size() != 0));
      chk("d0 busy",  32'(busy0),       32'(q0.size() != 0));
      chk("d0 ready", 32'(din_ready0),  32'(q0.size() <= PW0));
      if (q0.size() != 0) begin
        chk("d0 dout",  32'(dout0),       32'(q0[0].d));
        chk("d0 first", 32'(dout_first0), 32'(q0[0].f));
        chk("d0 last",  32'(dout_last0),  32'(q0[0].l));
      end
      chk("d1 valid", 32'(dout_valid1), 32'(q1.size() != 0));
      chk("d1 busy",  32'(busy1),       32'(q1.size() != 0));
      chk("d1 ready", 32'(din_ready1),  32'(q1.size() <= PW1));
      if (q1.size() != 0) begin
        chk("d1 dout",  32'(dout1),       32'(q1[0].d));
        chk("d1 first", 32'(dout_first1), 32'(q1[0].f));
        chk("d1 last",  32'(dout_last1),  32'(q1[0].l));
      end
    end
  end

  initial begin
    logic [7:0] a5_v;
    logic [1:0] b4_exp [4];
    int cnt_v;
    int cnt_nr;
    a5_v   = 8'hA5;
    b4_exp = '{2'b10, 2'b11, 2'b01, 2'b00};

    #2 rst = 1'b1;
    #1;
    chk("rst valid", 32'(dout_valid0), 32'd0);
    chk("rst dout",  32'(dout0),       32'd0);
    chk("rst busy",  32'(busy0),       32'd0);
    chk("rst ready", 32'(din_ready0),  32'd1);
    chk("rst first", 32'(dout_first0), 32'd0);
    chk("rst last",  32'(dout_last0),  32'd0);
    chk_en = 1'b1;
    @(posedge clk); #1 rst = 1'b0;

    // Single word 0xA5, LSB first
    @(posedge clk); #1 din_valid = 1'b1; din = 8'hA5;
    @(posedge clk); #1 din_valid = 1'b0;
    for (int i = 0; i < PW0; i++) begin
      @(negedge clk);
      if (i < 8) chk("a5 dout", 32'(dout0), 32'(a5_v[i]));
      else       chk("a5 parity", 32'(dout0), 32'(^a5_v));
      chk("a5 valid", 32'(dout_valid0), 32'd1);
      chk("a5 first", 32'(dout_first0), 32'(i == 0));
      chk("a5 last",  32'(dout_last0),  32'(i == PW0 - 1));
    end
    @(negedge clk);
    chk("a5 idle valid", 32'(dout_valid0), 32'd0);
    chk("a5 idle busy",  32'(busy0),       32'd0);

    // Single word 0xB4 on the 2-lane MSB-first instance
    @(posedge clk); #1 din_valid = 1'b1; din = 8'hB4;
    @(posedge clk); #1 din_valid = 1'b0;
    for (int i = 0; i < PW1; i++) begin
      @(negedge clk);
      if (i < 4) chk("b4 dout", 32'(dout1), 32'(b4_exp[i]));
      chk("b4 valid", 32'(dout_valid1), 32'd1);
    end
    @(negedge clk);
    chk("b4 end valid", 32'(dout_valid1), 32'd0);
    repeat (12) @(posedge clk);

    // Back-to-back 0x0F then 0xF0 with din_valid held
    #1 din_valid = 1'b1; din = 8'h0F;
    @(posedge clk); #1 din = 8'hF0;
    cnt_v = 0; cnt_nr = 0;
    for (int j = 0; j < 2 * PW0 + 3; j++) begin
      @(negedge clk);
      cnt_v  += int'(dout_valid0);
      cnt_nr += int'(!din_ready0);
      @(posedge clk); #1;
      if (j == 0) din_valid = 1'b0;
    end
    chk("b2b valid beats", 32'(cnt_v),  32'(2 * PW0));
    chk("b2b ready low",   32'(cnt_nr), 32'(PW0 - 1));
    repeat (4) @(posedge clk);

    // New word offered exactly on the final beat of the previous one
    #1 din_valid = 1'b1; din = 8'h5A;
    @(posedge clk); #1 din_valid = 1'b0;
    cnt_v = 0;
    for (int j = 0; j < 2 * PW0 + 3; j++) begin
      @(negedge clk);
      cnt_v += int'(dout_valid0);
      @(posedge clk); #1;
      if (j == PW0 - 2) begin din_valid = 1'b1; din = 8'h3C; end
      if (j == PW0 - 1) din_valid = 1'b0;
    end
    chk("final-beat accept beats", 32'(cnt_v), 32'(2 * PW0));
    repeat (4) @(posedge clk);

    // Reset on beat 3 while the holding register is full
    #1 din_valid = 1'b1; din = 8'hC3;
    @(posedge clk); #1 din = 8'h96;
    @(posedge clk); #1 din_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("mid rst valid", 32'(dout_valid0), 32'd0);
    chk("mid rst busy",  32'(busy0),       32'd0);
    chk("mid rst ready", 32'(din_ready0),  32'd1);
    chk("mid rst dout",  32'(dout0),       32'd0);
    @(posedge clk); #1 rst = 1'b0;
    cnt_v = 0;
    repeat (12) begin
      @(negedge clk);
      cnt_v += int'(dout_valid0) + int'(dout_valid1);
    end
    chk("post rst beats", 32'(cnt_v), 32'd0);

`ifdef PTOS_PARITY_EN
    // Parity beat values
    @(posedge clk); #1 din_valid = 1'b1; din = 8'h07;
    @(posedge clk); #1 din_valid = 1'b0;
    repeat (PW0) @(negedge clk);
    chk("par 07 bit",  32'(dout0),      32'd1);
    chk("par 07 last", 32'(dout_last0), 32'd1);
    repeat (4) @(posedge clk);
    #1 din_valid = 1'b1; din = 8'h03;
    @(posedge clk); #1 din_valid = 1'b0;
    repeat (PW0) @(negedge clk);
    chk("par 03 bit",  32'(dout0),      32'd0);
    chk("par 03 last", 32'(dout_last0), 32'd1);
    repeat (4) @(posedge clk);
`endif

    // Randomized traffic with occasional resets
    repeat (3000) begin
      @(posedge clk); #1;
      din_valid = ($urandom_range(0, 3) != 0);
      din       = 8'($urandom);
      rst       = ($urandom_range(0, 599) == 0);
    end
    @(posedge clk); #1 din_valid = 1'b0; rst = 1'b0;
    repeat (20) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
